rom_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the 32K-word instruction ROM. It accepts a byte stream over a valid/ready interface, assembles 16-bit big-endian instruction words and writes them to consecutive ROM addresses from 0. It holds the CPU in reset until a complete image has been written.

---
 rtl/rom_loader_pkg.sv | 31 +++
 rtl/rom_loader_csum.sv | 41 ++++
 rtl/rom_loader.sv | 193 +++++++++++++++++++
 tb/tb_rom_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, byte-stream field order, length and checksum widths.
package rom_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM_HI = 4'd6,
        ST_CSUM_LO = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERROR   = 4'd9
    } state_t;

    // Byte order on the stream: length (big-endian), N data words as HI/LO
    // pairs, then an optional big-endian checksum.
    localparam int FLD_LEN_HI    = 0;
    localparam int FLD_LEN_LO    = 1;
    localparam int FLD_DATA_BASE = 2;
    localparam int BYTES_PER_WORD = 2;

    localparam int LEN_W  = 16;
    localparam int CSUM_W = 16;

endpackage

// File: rtl/rom_loader_csum.sv
// Checksum accumulator: modulo-2**16 sum of written words with compare.
// Latency: sum updates one cycle after add; match is combinational on cmp_dat.
// Backpressure: none; driven by the loader FSM only.
//
// Ports: clk, reset (async, active-high), clr (zero the sum), add/add_dat
// (accumulate a word), cmp_dat (expected sum), match (sum == cmp_dat).
module rom_loader_csum
    import rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic [CSUM_W-1:0] add_dat,
    input  logic [CSUM_W-1:0] cmp_dat,
    output logic              match
);

    logic [CSUM_W-1:0] sum_q;
    logic [CSUM_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + add_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match = (sum_q == cmp_dat);

endmodule

// File: rtl/rom_loader.sv
// Boot loader: assembles big-endian 16-bit words from a byte stream into ROM.
// Latency: wr_en one cycle after the LO byte; >= 3 cycles per word.
// Backpressure: rx_ready drops in IDLE/WRITE/DONE/ERROR; stream stalls there.
//
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (adds trailing checksum check).
// Ports: clk, reset (async, active-high), start (begin load when not busy),
// rx_valid/rx_byte/rx_ready (byte stream), wr_en/wr_addr/wr_data (ROM write),
// cpu_reset (held high until a load succeeds), busy/done/error (status).
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    // One extra bit so a full 2**ADDR_W image can count past the last address.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic [LEN_W-1:0]  len_w;
    logic              too_long;
    logic              unused_addr_msb;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_hi_q, csum_hi_d;
    logic              csum_clr;
    logic              csum_add;
    logic              csum_match;

    rom_loader_csum u_csum (
        .clk     (clk),
        .reset   (reset),
        .clr     (csum_clr),
        .add     (csum_add),
        .add_dat ({hi_q, lo_q}),
        .cmp_dat ({csum_hi_q, rx_byte}),
        .match   (csum_match)
    );
`endif

    assign accept   = rx_valid & rx_ready;
    assign len_w    = {len_hi_q, rx_byte};
    assign too_long = 32'(len_w) > (32'd1 << ADDR_W);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_hi_d = csum_hi_q;
        csum_clr  = 1'b0;
        csum_add  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    addr_d  = '0;
                    cnt_d   = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_clr = 1'b1;
`endif
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_byte;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    cnt_d = len_w;
                    if (len_w == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM_HI;
`else
                        state_d = ST_DONE;
`endif
                    end else if (too_long) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_byte;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_byte;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                csum_add = 1'b1;
`endif
                if (cnt_q != 16'd1) begin
                    state_d = ST_DATA_HI;
                end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM_HI;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CSUM_HI: begin
                if (accept) begin
                    csum_hi_d = rx_byte;
                    state_d   = ST_CSUM_LO;
                end
            end
            ST_CSUM_LO: begin
                if (accept) begin
                    state_d = csum_match ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_hi_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_hi_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_hi_q <= csum_hi_d;
`endif
        end
    end

    // All outputs are pure decodes of registers: no input-to-output paths.
    assign rx_ready = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO)  ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CSUM_HI) || (state_q == ST_CSUM_LO);
    assign wr_en     = (state_q == ST_WRITE);
    assign wr_addr   = addr_q[ADDR_W-1:0];
    assign wr_data   = {hi_q, lo_q};
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign cpu_reset = (state_q != ST_DONE);

    // Counter MSB only exists to hold the one-past-the-end value.
    assign unused_addr_msb = addr_q[ADDR_W];

endmodule

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
module tb_rom_loader;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    rom_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       dat;
    } wr_t;

    logic [7:0]  stream[$];
    wr_t         exp_q[$];
    logic [15:0] rom[0:63];
    int          cur_n = 0;

    // Derive expected writes, bytes consumed and outcome from the stream rules.
    task automatic plan_load(output int consume, output bit exp_err);
        int n;
        logic [15:0] sum;
        logic [15:0] w;
        n = {stream[0], stream[1]};
        exp_q.delete();
        if (n > (1 << ADDR_W)) begin
            consume = 2;
            exp_err = 1'b1;
            cur_n   = 0;
        end else begin
            sum = 16'h0;
            for (int i = 0; i < n; i++) begin
                w = {stream[2 + 2*i], stream[3 + 2*i]};
                exp_q.push_back({ADDR_W'(i), w});
                sum = sum + w;
            end
            consume = 2 + 2*n;
            cur_n   = n;
`ifdef ROM_LOADER_CHECKSUM_EN
            consume = consume + 2;
            exp_err = ({stream[consume-2], stream[consume-1]} != sum);
`else
            exp_err = 1'b0;
`endif
        end
    endtask

    task automatic build_fixed3();
        stream = {8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
`ifdef ROM_LOADER_CHECKSUM_EN
        stream.push_back(8'hBE);
        stream.push_back(8'h00);
`endif
    endtask

    task automatic build_rand(input int n, input bit bad_csum);
        logic [15:0] sum;
        logic [15:0] w;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        sum = 16'h0;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            sum = sum + w;
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        if (bad_csum) sum = sum ^ 16'h0001;
        stream.push_back(sum[15:8]);
        stream.push_back(sum[7:0]);
`else
        if (bad_csum) sum = 16'h0;
`endif
    endtask

    // ---------------- per-cycle compare ----------------
    logic lo_pend = 1'b0;
    int   bidx = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                lo_pend = 1'b0;
                bidx = 0;
            end else begin
                check("wr_en_timing", wr_en, lo_pend);
                check("cpu_reset_vs_done", cpu_reset, !done);
                check("status_exclusive", ($countones({busy, done, error}) <= 1), 1'b1);
                check("rx_ready_only_busy", (rx_ready && !busy), 1'b0);
                if (wr_en) begin
                    check("write_expected", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        check("wr_addr", wr_addr, exp_q[0].addr);
                        check("wr_data", wr_data, exp_q[0].dat);
                        void'(exp_q.pop_front());
                    end
                    if (wr_addr < 64) rom[wr_addr[5:0]] = wr_data;
                end
                lo_pend = 1'b0;
                if (rx_valid && rx_ready) begin
                    if (bidx >= 2 && bidx < 2 + 2*cur_n && ((bidx - 2) % 2 == 1))
                        lo_pend = 1'b1;
                    bidx++;
                end
                if (start && !busy) bidx = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_stream(input int consume, input bit toggle, input bit pulse, input int abort_at);
        int  idx;
        int  budget;
        bit  phase;
        bit  on;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        budget = 0;
        phase = 1'b1;
        while (idx < consume && budget < 2000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            on = !toggle || phase;
            phase = !phase;
            rx_valid = on;
            rx_byte  = on ? stream[idx] : 8'($urandom);
            start    = pulse && ($urandom_range(0, 2) == 0);
            if (on && rx_ready) idx++;
            @(negedge clk);
            budget++;
        end
        rx_valid = 1'b0;
        start = 1'b0;
        check("stream_budget", (budget < 2000), 1'b1);
    endtask

    task automatic finish_load(input bit exp_err, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        #2;
        while (busy && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        check({tag, "_settle"}, busy, 1'b0);
        check({tag, "_done"}, done, !exp_err);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_cpu_reset"}, cpu_reset, exp_err);
        check({tag, "_rx_ready"}, rx_ready, 1'b0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic run_load(input bit toggle, input bit pulse, input string tag);
        int consume;
        bit exp_err;
        plan_load(consume, exp_err);
        drive_stream(consume, toggle, pulse, -1);
        finish_load(exp_err, tag);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  consume;
        bit  exp_err;
        int  n;

        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        clear_rom();
        #1;
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic 3-word image, continuous valid.
        build_fixed3();
        run_load(1'b0, 1'b0, "fixed3");
        check("fixed3_rom0", rom[0], 16'h1234);
        check("fixed3_rom1", rom[1], 16'hABCD);
        check("fixed3_rom2", rom[2], 16'hFFFF);

        // Empty image.
        stream = {8'h00, 8'h00};
`ifdef ROM_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
        stream.push_back(8'h00);
`endif
        run_load(1'b0, 1'b0, "empty");

        // Length one beyond capacity.
        stream = {8'h80, 8'h01};
        run_load(1'b0, 1'b0, "too_long");

`ifdef ROM_LOADER_CHECKSUM_EN
        // Bad checksum: word still lands in ROM, load ends in ERROR.
        clear_rom();
        stream = {8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
        run_load(1'b0, 1'b0, "bad_csum");
        check("bad_csum_rom0", rom[0], 16'h0005);
`endif

        // Reset after the HI byte of word 1: only word 0 written.
        clear_rom();
        build_fixed3();
        plan_load(consume, exp_err);
        drive_stream(consume, 1'b0, 1'b0, 5);
        reset = 1'b1;
        #1;
        check("abort_pending_words", exp_q.size(), 2);
        check("abort_rx_ready", rx_ready, 1'b0);
        check("abort_cpu_reset", cpu_reset, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_rom0", rom[0], 16'h1234);
        check("abort_rom1", rom[1], 16'h0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_rom();
        build_fixed3();
        run_load(1'b0, 1'b0, "reload");
        check("reload_rom0", rom[0], 16'h1234);
        check("reload_rom2", rom[2], 16'hFFFF);

        // Toggling valid with stray start pulses mid-load.
        clear_rom();
        build_fixed3();
        run_load(1'b1, 1'b1, "toggle");
        check("toggle_rom0", rom[0], 16'h1234);
        check("toggle_rom1", rom[1], 16'hABCD);
        check("toggle_rom2", rom[2], 16'hFFFF);

        // Randomized images.
        for (int t = 0; t < 10; t++) begin
            if (t == 6) begin
                n = $urandom_range(16'h8001, 16'hFFFF);
                stream = {8'(n >> 8), 8'(n)};
            end else begin
                build_rand($urandom_range(1, 12), ($urandom_range(0, 3) == 0));
            end
            run_load(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
